data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl.sv | 162 ++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory controller with a fixed-latency request/response
// handshake. One transaction in flight; loads are sign/zero-extended, stores
// write only the addressed bytes, and faulting accesses leave memory untouched.
module data_memory_ctrl #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned AW       = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;

  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;

  logic [7:0]  mem [DEPTH_BYTES];

  logic        accept;
  logic        commit;

  logic [2:0]  nbytes;
  logic [32:0] last_addr;
  logic        size_bad;
  logic        misaligned;
  logic        out_of_range;
  logic        err;

  logic [AW-1:0] base;
  logic [7:0]    rb [4];
  logic [31:0]   rext;

  // Ready is gated by reset so it reads 0 while held in reset and 1 as soon as
  // reset is released with the FSM sitting in IDLE.
  assign req_ready_o = rst_n_i && (state == S_IDLE);
  assign accept      = (state == S_IDLE) && req_valid_i;
  assign commit      = (state == S_WAIT) && (cnt == '0);
  assign base        = addr_q[AW-1:0];

  // Capture the whole request on acceptance so later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= req_we_i;
      addr_q  <= req_addr_i;
      size_q  <= req_size_i;
      uns_q   <= req_unsigned_i;
      wdata_q <= req_wdata_i;
    end
  end

  // Fault detection: illegal size, misalignment, and range check on the last
  // touched byte using a 33-bit sum so addresses near 2^32 cannot wrap.
  always_comb begin
    nbytes     = 3'd1;
    size_bad   = 1'b0;
    misaligned = 1'b0;
    case (size_q)
      2'b00: nbytes = 3'd1;
      2'b01: begin
        nbytes     = 3'd2;
        misaligned = addr_q[0];
      end
      2'b10: begin
        nbytes     = 3'd4;
        misaligned = |addr_q[1:0];
      end
      default: size_bad = 1'b1;
    endcase
    last_addr    = {1'b0, addr_q} + 33'(nbytes) - 33'd1;
    out_of_range = last_addr >= 33'(DEPTH_BYTES);
    err          = size_bad | misaligned | out_of_range;
  end

  // Gather the four bytes starting at the base address and extend per size.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      rb[k] = mem[base + AW'(k)];
    end
    case (size_q)
      2'b00:   rext = uns_q ? {24'd0, rb[0]} : {{24{rb[0][7]}}, rb[0]};
      2'b01:   rext = uns_q ? {16'd0, rb[1], rb[0]} : {{16{rb[1][7]}}, rb[1], rb[0]};
      default: rext = {rb[3], rb[2], rb[1], rb[0]};
    endcase
  end

  // Memory array: written only on the commit edge of a fault-free store; never reset.
  always_ff @(posedge clk_i) begin
    if (commit && we_q && !err) begin
      mem[base] <= wdata_q[7:0];
      if (size_q != 2'b00) begin
        mem[base + AW'(1)] <= wdata_q[15:8];
      end
      if (size_q == 2'b10) begin
        mem[base + AW'(2)] <= wdata_q[23:16];
        mem[base + AW'(3)] <= wdata_q[31:24];
      end
    end
  end

  // Control FSM: IDLE accepts, WAIT counts down to the commit edge, RESP holds
  // the response until the consumer takes it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            state <= S_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state        <= S_RESP;
            resp_valid_o <= 1'b1;
            resp_rdata_o <= (err || we_q) ? '0 : rext;
            resp_err_o   <= err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            state        <= S_IDLE;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed scoreboard bench for data_memory_ctrl: one instance at LATENCY=2
// for the functional and error cases, one at LATENCY=4 for reset-abort.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [1:0]  req_size   [2];
  logic        req_uns    [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  data_memory_ctrl #(.DEPTH_BYTES(1024), .LATENCY(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_we_i(req_we[0]), .req_addr_i(req_addr[0]), .req_size_i(req_size[0]),
    .req_unsigned_i(req_uns[0]), .req_wdata_i(req_wdata[0]),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0])
  );

  data_memory_ctrl #(.DEPTH_BYTES(1024), .LATENCY(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_we_i(req_we[1]), .req_addr_i(req_addr[1]), .req_size_i(req_size[1]),
    .req_unsigned_i(req_uns[1]), .req_wdata_i(req_wdata[1]),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic ST = 1'b1;
  localparam logic LD = 1'b0;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input int i, input string tag);
    chk({tag, "_req_ready"},  32'(req_ready[i]),  32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid[i]), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata[i],      32'd0);
    chk({tag, "_resp_err"},   32'(resp_err[i]),   32'd0);
  endtask

  // One complete transaction: push expectation, issue, measure latency,
  // pop and compare, optionally hold off the response for `hold` cycles.
  task automatic xact(input int i, input logic we, input logic [31:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee, input string tag,
                      input int hold);
    int   n;
    exp_t e;
    sb.push_back('{er, ee, tag});
    n = 0;
    @(negedge clk);
    while (req_ready[i] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready[i]), 32'd1);
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_size[i]  = size;
    req_uns[i]   = uns;
    req_wdata[i] = wd;
    req_valid[i] = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the captured request must be unaffected.
    req_valid[i] = (hold > 0);
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    req_we[i]    = ~we;
    req_size[i]  = ~size;
    req_uns[i]   = ~uns;
    n = 0;
    while (resp_valid[i] !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, lat_of(i));
    e = '{32'hx, 1'bx, "none"};
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    else e = sb.pop_front();
    chk({e.tag, "_rdata"}, resp_rdata[i], e.rdata);
    chk({e.tag, "_err"}, 32'(resp_err[i]), 32'(e.err));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(resp_valid[i]), 32'd1);
      chk({tag, "_hold_rdata"}, resp_rdata[i], e.rdata);
      chk({tag, "_hold_err"},   32'(resp_err[i]), 32'(e.err));
      chk({tag, "_hold_ready"}, 32'(req_ready[i]), 32'd0);
    end
    req_valid[i]  = 1'b0;
    resp_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[i] = 1'b0;
    chk({tag, "_done_valid"}, 32'(resp_valid[i]), 32'd0);
    chk({tag, "_done_ready"}, 32'(req_ready[i]), 32'd1);
    if (hold > 0) begin
      for (int k = 0; k < lat_of(i) + 1; k++) begin
        @(posedge clk);
        #1;
        chk({tag, "_no_second_accept"}, 32'(resp_valid[i]), 32'd0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i]      = 1'b0;
      req_valid[i]  = 1'b0;
      req_we[i]     = 1'b0;
      req_addr[i]   = '0;
      req_size[i]   = 2'b00;
      req_uns[i]    = 1'b0;
      req_wdata[i]  = '0;
      resp_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs(0, "rst0");
    chk_reset_outputs(1, "rst1");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    #1;
    chk("ready_after_rst0", 32'(req_ready[0]), 32'd1);
    chk("ready_after_rst1", 32'(req_ready[1]), 32'd1);

    // Word store/load and extension
    xact(0, ST, 32'h10, W, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, "st_w10",   0);
    xact(0, LD, 32'h10, W, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, "ld_w10",   0);
    xact(0, LD, 32'h13, B, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0, "ld_sb13",  0);
    xact(0, LD, 32'h12, H, 1'b1, 32'h0,        32'h0000DEAD, 1'b0, "ld_uh12",  0);
    xact(0, LD, 32'h10, B, 1'b0, 32'h0,        32'hFFFFFFEF, 1'b0, "ld_sb10",  0);
    xact(0, LD, 32'h12, H, 1'b0, 32'h0,        32'hFFFFDEAD, 1'b0, "ld_sh12",  0);
    xact(0, LD, 32'h13, B, 1'b1, 32'h0,        32'h000000DE, 1'b0, "ld_ub13",  0);

    // Partial stores
    xact(0, ST, 32'h11, B, 1'b0, 32'hAAAAAA55, 32'h0,        1'b0, "st_b11",   0);
    xact(0, LD, 32'h10, W, 1'b0, 32'h0,        32'hDEAD55EF, 1'b0, "ld_w10b",  0);
    xact(0, ST, 32'h12, H, 1'b0, 32'h7777CAFE, 32'h0,        1'b0, "st_h12",   0);
    xact(0, LD, 32'h10, W, 1'b0, 32'h0,        32'hCAFE55EF, 1'b0, "ld_w10h",  0);

    // Faults
    xact(0, LD, 32'h11,  H, 1'b0, 32'h0,        32'h0,        1'b1, "err_h11",  0);
    xact(0, LD, 32'h3FE, W, 1'b0, 32'h0,        32'h0,        1'b1, "err_w3fe", 0);
    xact(0, LD, 32'h10,  X, 1'b0, 32'h0,        32'h0,        1'b1, "err_sz11", 0);
    xact(0, ST, 32'h3FC, W, 1'b0, 32'h11223344, 32'h0,        1'b0, "st_w3fc",  0);
    xact(0, LD, 32'h3FC, W, 1'b0, 32'h0,        32'h11223344, 1'b0, "ld_w3fc",  0);
    xact(0, ST, 32'h3FD, W, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1, "err_st3fd",0);
    xact(0, LD, 32'h3FC, W, 1'b0, 32'h0,        32'h11223344, 1'b0, "ld_w3fc2", 0);
    xact(0, LD, 32'h3FF, B, 1'b1, 32'h0,        32'h00000011, 1'b0, "ld_ub3ff", 0);
    xact(0, LD, 32'h3FE, H, 1'b1, 32'h0,        32'h00001122, 1'b0, "ld_uh3fe", 0);
    xact(0, LD, 32'h400, B, 1'b1, 32'h0,        32'h0,        1'b1, "err_b400", 0);
    xact(0, LD, 32'hFFFFFFFC, W, 1'b0, 32'h0,   32'h0,        1'b1, "err_wrap", 0);
    xact(0, ST, 32'h0,   W, 1'b0, 32'h01020304, 32'h0,        1'b0, "st_w0",    0);
    xact(0, ST, 32'h400, B, 1'b0, 32'h00000099, 32'h0,        1'b1, "err_st400",0);
    xact(0, LD, 32'h0,   W, 1'b0, 32'h0,        32'h01020304, 1'b0, "ld_w0",    0);
    xact(0, ST, 32'h8,   X, 1'b0, 32'h12345678, 32'h0,        1'b1, "err_stx",  0);

    // Backpressure with a pending request held on the input
    xact(0, LD, 32'h10, W, 1'b0, 32'h0, 32'hCAFE55EF, 1'b0, "bp_w10", 5);

    // Reset in WAIT on the LATENCY=4 instance
    xact(1, ST, 32'h20, W, 1'b0, 32'hA5A5A5A5, 32'h0,        1'b0, "l4_st",  0);
    xact(1, LD, 32'h20, W, 1'b0, 32'h0,        32'hA5A5A5A5, 1'b0, "l4_ld",  0);
    @(negedge clk);
    chk("abort_ready", 32'(req_ready[1]), 32'd1);
    req_we[1]    = ST;
    req_addr[1]  = 32'h20;
    req_size[1]  = W;
    req_uns[1]   = 1'b0;
    req_wdata[1] = 32'h12345678;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[1] = 1'b0;
    #1;
    chk_reset_outputs(1, "abort_rst");
    @(posedge clk);
    #1;
    chk_reset_outputs(1, "abort_rst_edge");
    @(negedge clk);
    rst_n[1] = 1'b1;
    #1;
    chk("abort_ready_after", 32'(req_ready[1]), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("abort_no_resp", 32'(resp_valid[1]), 32'd0);
    end
    xact(1, LD, 32'h20, W, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0, "l4_ld_after", 0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
